// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule constants, key types, FSM states and the rotate/PC-2 helpers.
package des_pkg;
  localparam int DES_ROUNDS = 16;
  localparam logic [15:0] SHIFT_SCHED = 16'b1100_0000_1000_0001;
  typedef logic [0:55] key56_t;
  typedef logic [0:47] rkey48_t;
  typedef enum logic [1:0] {IDLE, GEN, SERVE} state_t;
  localparam logic [5:0] PC2 [48] = '{
    13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
  };
  function automatic key56_t rotate(key56_t k, logic one);
    return one ? {k[1:27], k[0], k[29:55], k[28]} : {k[2:27], k[0:1], k[30:55], k[28:29]};
  endfunction
  function automatic rkey48_t pc2(key56_t k);
    rkey48_t r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(i)] = k[PC2[6'(i)]];
    return r;
  endfunction
endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// des_key_sched_ctrl_if: key-load and round-key delivery handshakes of the key-schedule controller.
interface des_key_sched_ctrl_if;
  import des_pkg::*;
  logic key_valid, key_ready, decrypt, reuse;
  key56_t key_in;
  logic rk_valid, rk_ready, rk_last, busy;
  rkey48_t rk_out;
  logic [3:0] rk_round;
  modport master(output key_valid, key_in, decrypt, reuse, rk_ready,
                 input key_ready, rk_valid, rk_out, rk_round, rk_last, busy);
  modport slave(input key_valid, key_in, decrypt, reuse, rk_ready,
                output key_ready, rk_valid, rk_out, rk_round, rk_last, busy);
endinterface

// File: rtl/des_rk_store.sv
// des_rk_store: 16x48 round-key store, one write port, one combinational read port, bulk clear.
module des_rk_store import des_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic       clr,
  input  logic [3:0] waddr,
  input  logic [3:0] raddr,
  input  rkey48_t    wdata,
  output rkey48_t    rdata
);
  rkey48_t mem [16];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '{default: '0};
    else if (clr) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/round_key_gen.sv
// round_key_gen: one DES schedule step, C/D rotate by 1 or 2 then PC-2 compression.
module round_key_gen import des_pkg::*; (
  input  key56_t  cd,
  input  logic    shift,
  output key56_t  next_key,
  output rkey48_t rk
);
  assign next_key = rotate(cd, shift);
  assign rk = pc2(next_key);
endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: generates, stores and serves the 16 DES round keys; DES_KEY_REUSE_EN adds stored-key replay.
module des_key_sched_ctrl import des_pkg::*; #(
  parameter int ROUNDS  = DES_ROUNDS,
  parameter bit ZEROIZE = 1'b0
) (
  input logic clk,
  input logic rst_n,
  des_key_sched_ctrl_if.slave bus
);
  state_t state, state_nxt;
  key56_t cd, cd_nxt;
  rkey48_t rk_gen, rd_data;
  logic [3:0] cnt, ptr;
  logic dir, gen, serve, accept, gen_done, hs, fin, zero, reuse_go;
  if (ROUNDS != DES_ROUNDS) begin : g_bad_rounds
    $error("des_key_sched_ctrl supports ROUNDS = 16 only");
  end
  assign gen      = state == GEN;
  assign serve    = state == SERVE;
  assign accept   = state == IDLE && bus.key_valid;
  assign gen_done = gen && cnt == 4'(ROUNDS - 1);
  assign hs       = serve && bus.rk_ready;
  assign fin      = hs && bus.rk_last;
  assign zero     = fin && ZEROIZE;
`ifdef DES_KEY_REUSE_EN
  logic store_valid;
  assign reuse_go = state == IDLE && !bus.key_valid && bus.reuse && store_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) store_valid <= 1'b0;
    else if (accept || zero) store_valid <= 1'b0;
    else if (gen_done) store_valid <= 1'b1;
`else
  logic unused_reuse;
  assign unused_reuse = bus.reuse;
  assign reuse_go = 1'b0;
`endif
  round_key_gen u_gen (.cd(cd), .shift(SHIFT_SCHED[4'd15 - cnt]), .next_key(cd_nxt), .rk(rk_gen));
  des_rk_store u_store (.clk(clk), .rst_n(rst_n), .we(gen), .clr(zero), .waddr(cnt),
                        .raddr(ptr), .wdata(rk_gen), .rdata(rd_data));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? GEN : (reuse_go || gen_done) ? SERVE : fin ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cd  <= '0;
      cnt <= '0;
      ptr <= '0;
      dir <= 1'b0;
    end else begin
      if (accept) begin
        cd  <= bus.key_in;
        dir <= bus.decrypt;
        cnt <= '0;
      end
      if (gen) begin
        cd  <= cd_nxt;
        cnt <= cnt + 4'd1;
      end
      if (gen_done) ptr <= dir ? 4'd15 : 4'd0;
      if (reuse_go) begin
        dir <= bus.decrypt;
        ptr <= bus.decrypt ? 4'd15 : 4'd0;
      end
      if (hs && !bus.rk_last) ptr <= dir ? ptr - 4'd1 : ptr + 4'd1;
      if (zero) cd <= '0;
    end
  assign bus.key_ready = state == IDLE;
  assign bus.busy      = gen || serve;
  assign bus.rk_valid  = serve;
  assign bus.rk_out    = serve ? rd_data : '0;
  assign bus.rk_round  = serve ? ptr : 4'd0;
  assign bus.rk_last   = serve && (dir ? ptr == 4'd0 : ptr == 4'd15);
endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
- Sequences the single-round DES key generator (one 56-bit C/D rotate plus PC-2 compression per step) over all 16 rounds.
- Stores the 16 round keys, then delivers them to the DES round datapath with a valid/ready handshake.
- Order is forward (K1..K16) for encrypt and reverse (K16..K1) for decrypt.
- Sits between the PC-1 key loader and the Feistel round engine.

Parameters:
- ROUNDS, 16, number of schedule steps; only 16 is supported, so any other value is an elaboration error.
- ZEROIZE, 0, when 1 the key store and the C/D register are cleared to 0 after the last round key is consumed.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  a new post-PC-1 key is offered.
- key_ready  out  1  the block can accept a key.
- key_in  in  56  [0:55] post-PC-1 key, C=[0:27], D=[28:55].
- decrypt  in  1  sampled with the key: 0 = forward order, 1 = reverse order.
- reuse  in  1  replay the stored keys without regeneration (only with the optional feature).
- rk_valid  out  1  rk_out holds a valid round key.
- rk_ready  in  1  the consumer takes the round key.
- rk_out  out  48  [0:47] round key.
- rk_round  out  4  index of the delivered key, 0..15 (Kn = n+1).
- rk_last  out  1  the current key is the final one of the sequence.
- busy  out  1  high in GEN or SERVE.

Behaviour:
- Reset values: all outputs 0 except key_ready = 1. State = IDLE, C/D register = 0, key store = 0, round counter = 0, dir = 0.
- States:
  - IDLE: key_ready = 1. On key_valid & key_ready, latch key_in into the C/D register, latch decrypt into dir, clear the counter, go to GEN.
  - GEN: one schedule step per cycle. Drive the generator with shift = SHIFT_SCHED[cnt] (1 = rotate by 1, 0 = rotate by 2). Write next_key into C/D and write the compressed key into store[cnt]. Increment cnt; after the write at cnt = 15, go to SERVE with ptr = dir ? 15 : 0.
  - SERVE: rk_valid = 1, rk_out = store[ptr] (registered), rk_round = ptr. rk_last = 1 when ptr = 15 (encrypt) or ptr = 0 (decrypt). On rk_valid & rk_ready, step ptr by ±1. On a handshake with rk_last, go to IDLE (zeroize first if ZEROIZE = 1).
- Latency: key accepted in cycle T; GEN occupies cycles T+1..T+16; rk_valid first rises in cycle T+17. Sustained throughput is one key per cycle while rk_ready = 1.
- Handshake rules:
  - rk_out, rk_round and rk_last stay stable while rk_valid & !rk_ready.
  - rk_valid never drops without a handshake, except on reset.
- key_valid outside IDLE: key_ready = 0; the key is ignored and not queued.
- Final handshake and key_valid in the same cycle: the key is not accepted. key_ready rises the next cycle, then the key is accepted.
- Pointer wrap: ptr never wraps; the last-key handshake always exits SERVE.
- Counter: cnt is 4-bit, saturation is never reached, and cnt is cleared on entry to GEN.
- Reset mid-GEN or mid-SERVE: immediate return to the reset values; a partial key store is not valid for reuse.
- Cumulative rotation check: the total rotation over 16 steps is 28, so C/D equals key_in again at the end of GEN.

Optional Feature:
- Macro: DES_KEY_REUSE_EN.
- Defined: in IDLE, reuse = 1 (with key_valid = 0) and a store_valid flag set enters SERVE directly, with dir = decrypt at that edge and no GEN cycles. Latency: reuse in cycle T gives rk_valid in cycle T+1.
  - store_valid is set on GEN completion and cleared by reset, by ZEROIZE, and by accepting a new key.
  - key_valid has priority over reuse.
- Undefined: the reuse port is ignored and no store_valid flag is built.

Decomposition:
- Package des_pkg holds:
  - SHIFT_SCHED = 16'b1100_0000_1000_0001, indexed MSB = round 0 (a 1 marks the rotate-by-1 rounds 1, 2, 9 and 16).
  - DES_ROUNDS = 16.
  - Typedefs key56_t [0:55] and rkey48_t [0:47].
  - A state enum {IDLE, GEN, SERVE}.
- Sub-module: the existing round_key_gen is instantiated once and reused every cycle. The 16x48 store is a separate small module, des_rk_store, with 1 write port and 1 read port.

Test Plan:
- Encrypt, key_in = 56'hF0CCAAF556678F (PC-1 of 133457799BBCDFF1) -> rk_valid at T+17; K1 = 48'h1B02EFFC7072 with rk_round = 0; K16 = 48'hCB3D8B0E17F5 with rk_round = 15 and rk_last = 1.
- Same key with decrypt = 1 -> first rk_out = 48'hCB3D8B0E17F5, last = 48'h1B02EFFC7072 with rk_round = 0 and rk_last = 1.
- rk_ready toggled randomly 50% -> outputs held stable while stalled, exactly 16 handshakes, key_ready = 0 throughout, and key_valid pulses during busy are ignored.
- rst_n low in GEN at cnt = 7 -> all outputs at reset values asynchronously; a new key afterwards yields the correct K1..K16.
- Reuse (with DES_KEY_REUSE_EN): after an encrypt, reuse = 1 with decrypt = 1 -> rk_valid the next cycle with K16 first; without the macro, reuse does nothing.
- ZEROIZE = 1 -> after rk_last is consumed, the store and C/D read as 0 and a reuse attempt is rejected.
